// File: rtl/preg_free_list_pkg.sv
// -----------------------------------------------------------------------------
// preg_free_list_pkg
// Shared types and sizing for the physical-register free list.
//   p_reg      : physical register ID
//   fl_count_t : free-entry count, 0..FL_DEPTH inclusive
//   fl_ptr_t   : FIFO index, 0..FL_DEPTH-1
//   fl_inc_t   : per-cycle pointer increment, 0..3
// -----------------------------------------------------------------------------
package preg_free_list_pkg;

    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int ALLOC_W   = 2;
    localparam int FREE_W    = 3;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int CNT_W     = $clog2(FL_DEPTH + 1);
    localparam int PTR_W     = $clog2(FL_DEPTH);

    typedef logic [PREG_W-1:0] p_reg;
    typedef logic [CNT_W-1:0]  fl_count_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [1:0]        fl_inc_t;

    function automatic fl_inc_t popcount3(input logic [2:0] v);
        return fl_inc_t'(v[0]) + fl_inc_t'(v[1]) + fl_inc_t'(v[2]);
    endfunction

endpackage

// File: rtl/preg_free_list_ptr_adv.sv
// -----------------------------------------------------------------------------
// preg_ptr_adv
// Combinational wrap-around pointer add: o_ptr = (i_ptr + i_inc) mod FL_DEPTH.
// FL_DEPTH is not a power of two, so the wrap is an explicit subtract.
//   i_ptr : current FIFO index (0..FL_DEPTH-1)
//   i_inc : increment, 0..3
//   o_ptr : advanced index
// -----------------------------------------------------------------------------
module preg_ptr_adv
    import preg_free_list_pkg::*;
(
    input  fl_ptr_t i_ptr,
    input  fl_inc_t i_inc,
    output fl_ptr_t o_ptr
);

    localparam logic [PTR_W:0] DEPTH_X = (PTR_W+1)'(FL_DEPTH);

    logic [PTR_W:0] sum;

    always_comb begin
        sum = {1'b0, i_ptr} + {{(PTR_W-1){1'b0}}, i_inc};
        if (sum >= DEPTH_X) begin
            o_ptr = PTR_W'(sum - DEPTH_X);
        end else begin
            o_ptr = sum[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/preg_free_list.sv
// -----------------------------------------------------------------------------
// preg_free_list
// Circular FIFO of free physical register IDs feeding the rename stage.
// Grants up to ALLOC_W allocations per cycle (all-or-nothing) and accepts up
// to FREE_W returned IDs per cycle from retiring ROB rows.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_alloc_req     : per-slot allocation request
//   o_alloc_gnt     : every requested slot is granted this cycle
//   o_alloc_preg    : granted ID per slot (0 when not requested / not granted)
//   i_free_valid    : per-port free valid
//   i_free_preg     : per-port ID being returned (ID 0 is ignored)
//   o_free_count    : registered free-entry count
//   o_stall         : requests present but not granted
//   o_overflow_err  : sticky, a free arrived with no room left
// -----------------------------------------------------------------------------
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ALLOC_W-1:0]     i_alloc_req,
    output logic                   o_alloc_gnt,
    output p_reg [ALLOC_W-1:0]     o_alloc_preg,
    input  logic [FREE_W-1:0]      i_free_valid,
    input  p_reg [FREE_W-1:0]      i_free_preg,
    output fl_count_t              o_free_count,
    output logic                   o_stall,
    output logic                   o_overflow_err
);

    p_reg      fl_mem_q [FL_DEPTH];
    p_reg      fl_mem_d [FL_DEPTH];
    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_count_t count_q, count_d;
    logic      err_q, err_d;

    fl_inc_t           n_req;
    fl_inc_t           n_alloc;
    fl_inc_t           n_acc;
    logic              gnt;
    fl_ptr_t           head_p1;
    fl_count_t         count_after_alloc;
    fl_count_t         room;
    logic [FREE_W-1:0] free_eff;
    logic [FREE_W-1:0] free_acc;
    fl_inc_t           acc_idx [FREE_W];
    fl_ptr_t           wr_ptr  [FREE_W];
    logic              overflow;

    // ------------------------------------------------------------------
    // Allocation: depends only on registered head/count, never on frees.
    // ------------------------------------------------------------------
    assign n_req   = popcount3({1'b0, i_alloc_req});
    assign gnt     = (count_q >= fl_count_t'(n_req));
    assign n_alloc = gnt ? n_req : 2'd0;

    preg_ptr_adv u_head_p1 (
        .i_ptr (head_q),
        .i_inc (2'd1),
        .o_ptr (head_p1)
    );

    preg_ptr_adv u_head_next (
        .i_ptr (head_q),
        .i_inc (n_alloc),
        .o_ptr (head_d)
    );

    // Requested slots are compacted: the lowest requested slot takes head.
    always_comb begin
        o_alloc_preg = '0;
        if (gnt) begin
            if (i_alloc_req[0]) begin
                o_alloc_preg[0] = fl_mem_q[head_q];
                if (i_alloc_req[1]) begin
                    o_alloc_preg[1] = fl_mem_q[head_p1];
                end
            end else if (i_alloc_req[1]) begin
                o_alloc_preg[1] = fl_mem_q[head_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Free: compact valid non-zero IDs in port order, accepting only as
    // many as fit after this cycle's allocation.
    // ------------------------------------------------------------------
    always_comb begin
        count_after_alloc = count_q - fl_count_t'(n_alloc);
        room              = fl_count_t'(FL_DEPTH) - count_after_alloc;
        n_acc             = '0;
        free_eff          = '0;
        free_acc          = '0;
        for (int j = 0; j < FREE_W; j++) begin
            acc_idx[j]  = n_acc;
            free_eff[j] = i_free_valid[j] && (i_free_preg[j] != '0);
            if (free_eff[j] && (fl_count_t'(n_acc) < room)) begin
                free_acc[j] = 1'b1;
                n_acc       = n_acc + 2'd1;
            end
        end
        overflow = |(free_eff & ~free_acc);
    end

    for (genvar j = 0; j < FREE_W; j++) begin : g_wr_ptr
        preg_ptr_adv u_wr_ptr (
            .i_ptr (tail_q),
            .i_inc (acc_idx[j]),
            .o_ptr (wr_ptr[j])
        );
    end

    preg_ptr_adv u_tail_next (
        .i_ptr (tail_q),
        .i_inc (n_acc),
        .o_ptr (tail_d)
    );

    // Allocation reads [head, head+n_alloc) and frees write [tail, tail+n_acc);
    // the room limit above keeps these ranges disjoint.
    always_comb begin
        fl_mem_d = fl_mem_q;
        for (int j = 0; j < FREE_W; j++) begin
            if (free_acc[j]) begin
                fl_mem_d[wr_ptr[j]] = i_free_preg[j];
            end
        end
        count_d = count_after_alloc + fl_count_t'(n_acc);
        err_d   = err_q | overflow;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_count_t'(FL_DEPTH);
            err_q   <= 1'b0;
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl_mem_q[k] <= p_reg'(NUM_AREGS + k);
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
            fl_mem_q <= fl_mem_d;
        end
    end

    assign o_alloc_gnt    = gnt;
    assign o_stall        = ~gnt & (|i_alloc_req);
    assign o_free_count   = count_q;
    assign o_overflow_err = err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// -----------------------------------------------------------------------------
// tb_preg_free_list
// Directed stimulus against a queue model of the free pool. The model is
// compared with the DUT on every driven cycle; literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [ALLOC_W-1:0] i_alloc_req;
    logic               o_alloc_gnt;
    p_reg [ALLOC_W-1:0] o_alloc_preg;
    logic [FREE_W-1:0]  i_free_valid;
    p_reg [FREE_W-1:0]  i_free_preg;
    fl_count_t          o_free_count;
    logic               o_stall;
    logic               o_overflow_err;

    int checks = 0;
    int errors = 0;
    int model_q[$];
    bit model_err;

    always #5 i_clk = ~i_clk;

    preg_free_list dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_alloc_req    (i_alloc_req),
        .o_alloc_gnt    (o_alloc_gnt),
        .o_alloc_preg   (o_alloc_preg),
        .i_free_valid   (i_free_valid),
        .i_free_preg    (i_free_preg),
        .o_free_count   (o_free_count),
        .o_stall        (o_stall),
        .o_overflow_err (o_overflow_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        for (int k = 0; k < FL_DEPTH; k++) model_q.push_back(NUM_AREGS + k);
        model_err = 1'b0;
    endtask

    // Apply inputs, then at the falling edge compare every output to the model.
    task automatic drive(input logic [1:0] req, input logic [2:0] fv,
                         input int p0, input int p1, input int p2);
        int nr;
        int k;
        bit eg;
        int exp_slot[2];
        i_alloc_req    = req;
        i_free_valid   = fv;
        i_free_preg[0] = p_reg'(p0);
        i_free_preg[1] = p_reg'(p1);
        i_free_preg[2] = p_reg'(p2);
        @(negedge i_clk);
        nr = int'(req[0]) + int'(req[1]);
        eg = (model_q.size() >= nr);
        k  = 0;
        for (int s = 0; s < 2; s++) begin
            exp_slot[s] = 0;
            if (req[s]) begin
                if (eg) exp_slot[s] = model_q[k];
                k++;
            end
        end
        chk("gnt",   int'(o_alloc_gnt),     int'(eg));
        chk("slot0", int'(o_alloc_preg[0]), exp_slot[0]);
        chk("slot1", int'(o_alloc_preg[1]), exp_slot[1]);
        chk("stall", int'(o_stall),         int'(!eg && nr > 0));
        chk("count", int'(o_free_count),    model_q.size());
        chk("err",   int'(o_overflow_err),  int'(model_err));
    endtask

    // Clock edge: advance the model with the same inputs the DUT samples.
    task automatic tick();
        int nr;
        @(posedge i_clk);
        nr = int'(i_alloc_req[0]) + int'(i_alloc_req[1]);
        if (model_q.size() >= nr) begin
            repeat (nr) void'(model_q.pop_front());
        end
        for (int j = 0; j < FREE_W; j++) begin
            if (i_free_valid[j] && i_free_preg[j] != '0) begin
                if (model_q.size() < FL_DEPTH) model_q.push_back(int'(i_free_preg[j]));
                else model_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cyc(input logic [1:0] req, input logic [2:0] fv,
                       input int p0, input int p1, input int p2);
        drive(req, fv, p0, p1, p2);
        tick();
    endtask

    task automatic do_reset();
        i_rst_n      = 1'b0;
        i_alloc_req  = '0;
        i_free_valid = '0;
        i_free_preg  = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // 1: pair allocation straight out of reset
        do_reset();
        chk("rst_count", int'(o_free_count), 96);
        chk("rst_err",   int'(o_overflow_err), 0);
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("t1_p0", int'(o_alloc_preg[0]), 32);
        chk("t1_p1", int'(o_alloc_preg[1]), 33);
        chk("t1_gnt", int'(o_alloc_gnt), 1);
        tick();
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("t1_count", int'(o_free_count), 94);
        chk("t1_p0b", int'(o_alloc_preg[0]), 34);
        chk("t1_p1b", int'(o_alloc_preg[1]), 35);
        tick();

        // 2: only slot 1 requests
        do_reset();
        drive(2'b10, 3'b000, 0, 0, 0);
        chk("t2_p1", int'(o_alloc_preg[1]), 32);
        chk("t2_p0", int'(o_alloc_preg[0]), 0);
        tick();
        drive(2'b00, 3'b000, 0, 0, 0);
        chk("t2_count", int'(o_free_count), 95);
        tick();

        // 3: drain to one entry, pair request stalls, single request succeeds
        do_reset();
        repeat (47) cyc(2'b11, 3'b000, 0, 0, 0);
        cyc(2'b01, 3'b000, 0, 0, 0);
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("t3_gnt",   int'(o_alloc_gnt), 0);
        chk("t3_stall", int'(o_stall), 1);
        chk("t3_count", int'(o_free_count), 1);
        tick();
        drive(2'b01, 3'b000, 0, 0, 0);
        chk("t3_count_hold", int'(o_free_count), 1);
        chk("t3_gnt1", int'(o_alloc_gnt), 1);
        chk("t3_p0", int'(o_alloc_preg[0]), 127);
        tick();

        // 4: empty pool, same-cycle frees are not allocatable yet
        drive(2'b11, 3'b111, 40, 41, 42);
        chk("t4_gnt",   int'(o_alloc_gnt), 0);
        chk("t4_count", int'(o_free_count), 0);
        tick();
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("t4_count3", int'(o_free_count), 3);
        chk("t4_p0", int'(o_alloc_preg[0]), 40);
        chk("t4_p1", int'(o_alloc_preg[1]), 41);
        tick();

        // 5: PReg 0 is dropped, remaining frees compacted in port order
        drive(2'b00, 3'b111, 5, 0, 9);
        chk("t5_count", int'(o_free_count), 1);
        tick();
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("t5_count3", int'(o_free_count), 3);
        chk("t5_p0", int'(o_alloc_preg[0]), 42);
        chk("t5_p1", int'(o_alloc_preg[1]), 5);
        tick();
        drive(2'b01, 3'b000, 0, 0, 0);
        chk("t5_p0b", int'(o_alloc_preg[0]), 9);
        tick();

        // Tail is now 5; 30 triple frees bring it to 95, next triple wraps.
        for (int i = 0; i < 30; i++) cyc(2'b00, 3'b111, 1 + i, 31 + i, 61 + i);
        drive(2'b00, 3'b111, 100, 101, 102);
        chk("wrap_count90", int'(o_free_count), 90);
        tick();
        drive(2'b00, 3'b000, 0, 0, 0);
        chk("wrap_count93", int'(o_free_count), 93);
        tick();
        repeat (45) cyc(2'b11, 3'b000, 0, 0, 0);
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("wrap_p0", int'(o_alloc_preg[0]), 100);
        chk("wrap_p1", int'(o_alloc_preg[1]), 101);
        tick();
        drive(2'b01, 3'b000, 0, 0, 0);
        chk("wrap_p0b", int'(o_alloc_preg[0]), 102);
        tick();
        drive(2'b00, 3'b000, 0, 0, 0);
        chk("wrap_empty", int'(o_free_count), 0);
        tick();

        // 6: overflow at count 95, sticky error, then mid-burst reset
        do_reset();
        cyc(2'b01, 3'b000, 0, 0, 0);
        drive(2'b00, 3'b111, 7, 8, 9);
        chk("t6_count95", int'(o_free_count), 95);
        chk("t6_err0", int'(o_overflow_err), 0);
        tick();
        drive(2'b00, 3'b000, 0, 0, 0);
        chk("t6_err1", int'(o_overflow_err), 1);
        chk("t6_count96", int'(o_free_count), 96);
        tick();
        repeat (3) cyc(2'b00, 3'b000, 0, 0, 0);
        drive(2'b01, 3'b000, 0, 0, 0);
        chk("t6_err_sticky", int'(o_overflow_err), 1);
        chk("t6_p0", int'(o_alloc_preg[0]), 33);
        tick();

        drive(2'b11, 3'b111, 3, 4, 6);
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_count", int'(o_free_count), 96);
        chk("rst_mid_err", int'(o_overflow_err), 0);
        chk("rst_mid_p0", int'(o_alloc_preg[0]), 32);
        chk("rst_mid_p1", int'(o_alloc_preg[1]), 33);
        i_alloc_req  = '0;
        i_free_valid = '0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        drive(2'b11, 3'b000, 0, 0, 0);
        chk("post_rst_p0", int'(o_alloc_preg[0]), 32);
        chk("post_rst_p1", int'(o_alloc_preg[1]), 33);
        tick();
        cyc(2'b00, 3'b000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Owns the pool of free physical registers and hands them out to the rename stage.
- Replaces the per-slot linear scan of a free bitmap with a circular FIFO of free PReg IDs.
- Grants up to 2 destination allocations per cycle to the two rename slots, all-or-nothing.
- Accepts up to 3 frees per cycle, from OldPRegAddrDst of retiring ROB rows.
- Provides the stall signal that rename/decode use to hold the issue pair.

Parameters:
- NUM_PREGS, 128: physical register count.
- NUM_AREGS, 32: architectural register count; PRegs 0..NUM_AREGS-1 are mapped at reset.
- ALLOC_W, 2: allocation slots per cycle.
- FREE_W, 3: free ports per cycle; matches ROB retire width.
- PREG_W, $clog2(NUM_PREGS)=7: PReg ID width.
- FL_DEPTH, NUM_PREGS-NUM_AREGS=96: FIFO capacity (derived, not overridable).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_alloc_req  in  ALLOC_W  bit i set: slot i needs a destination PReg.
- o_alloc_gnt  out  1  all requested slots are granted this cycle.
- o_alloc_preg  out  ALLOC_W x PREG_W  PReg ID per slot; valid when its req and o_alloc_gnt are both set.
- i_free_valid  in  FREE_W  free port j carries a PReg to return.
- i_free_preg  in  FREE_W x PREG_W  PReg ID to return.
- o_free_count  out  $clog2(FL_DEPTH+1)  current free-entry count (registered).
- o_stall  out  1  high when o_alloc_gnt=0 and i_alloc_req!=0.
- o_overflow_err  out  1  sticky; set when a free would exceed capacity.

Behaviour:
State:
- fl_mem[0:FL_DEPTH-1], head, tail (both 0..FL_DEPTH-1), count.
- Pointers wrap explicitly: FL_DEPTH-1 -> 0. Depth is not a power of two, so no bit-truncation wrap.

Reset (async assert, sync release):
- fl_mem[k]=NUM_AREGS+k, head=0, tail=0, count=96.
- o_overflow_err=0, o_free_count=96.
- Reset mid-operation discards all in-flight state and returns to the reset pool.

Allocation (combinational grant, same cycle):
- n_req = popcount(i_alloc_req).
- o_alloc_gnt = (count >= n_req); req=0 gives gnt=1.
- Requested slots are compacted in slot order. The lowest requested slot gets fl_mem[head]; the next requested slot gets fl_mem[head+1 wrapped].
- Unrequested slot outputs 0.
- On gnt: head advances by n_req at the clock edge. On no gnt: head is unchanged and o_stall=1.
- No partial grants.
- o_alloc_preg is driven from the registered head and count only. No path from i_free_* to o_alloc_*.

Free (write at clock edge):
- Ports with i_free_valid=1 and i_free_preg!=0 are compacted in port order and written at tail, tail+1, tail+2 (wrapped). tail advances by n_free.
- PReg 0 is never freed; it is dropped silently.
- Frees written this cycle become allocatable next cycle at the earliest.

Count and overflow:
- count_next = count - (gnt ? n_req : 0) + n_free.
- If this exceeds FL_DEPTH: accept only FL_DEPTH - (count - alloc) entries in port order, drop the rest, and set o_overflow_err. It stays set until reset.
- Simultaneous alloc and free at the same index is impossible. Allocation reads entries [head, head+n_req) and free writes [tail, tail+n_free); these cannot overlap while count_next <= FL_DEPTH.

Duplicate frees of the same PReg are not detected; that is a verification assertion, not RTL.

Decomposition:
- Add to shared Types package: p_reg (PREG_W), NUM_PREGS, NUM_AREGS, FL_DEPTH, and typedef fl_count_t.
- Sub-module: preg_ptr_adv, a combinational wrap-around pointer add (ptr + 0..3 mod FL_DEPTH). Instantiated for head and for each tail offset.

Test Plan:
1. Reset, then i_alloc_req=2'b11 -> gnt=1, o_alloc_preg={32,33}; next cycle count=94, next pair {34,35}.
2. i_alloc_req=2'b10 after reset -> slot1 gets 32, slot0 outputs 0; count=95.
3. Drain to count=1, i_alloc_req=2'b11 -> gnt=0, o_stall=1, head and count unchanged. Then req=2'b01 -> gnt=1, slot0 gets 127, count=0.
4. At count=0: alloc req 2'b11 plus frees {40,41,42} in the same cycle -> gnt=0, count=3 next cycle. Next cycle req 2'b11 -> {40,41}.
5. Free valid=3'b111, pregs {5,0,9} -> only 5 and 9 appended in order, count+2. Wrap check: with tail=95, freeing 3 writes indices 95, 0, 1.
6. At count=95, free 3 with no alloc -> one entry accepted, o_overflow_err=1 and stays set. Assert i_rst_n=0 mid-burst -> immediate reset state: count=96, err=0, first alloc yields 32.
